// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared state encoding, default sizing and width helpers for the FIFO read prefetcher
package fifo_rd_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int RD_LAT_DEF = 2;
    localparam int DEPTH_DEF  = 4;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// fifo_rd_buf: circular prefetch buffer with tail write, head advance and synchronous clear (non power-of-2 depth allowed)
module fifo_rd_buf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    rclk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic [cnt_w(DEPTH)-1:0] cnt
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // clear wins over any write or advance on the same edge
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        mem_d  = mem_q;
        if (clr) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[tail_q] = wr_data;
                tail_d        = nxt(tail_q);
            end
            if (rd_en) head_d = nxt(head_q);
            cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    // buffer state registers
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            mem_q  <= '{default: '0};
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            mem_q  <= mem_d;
        end
    end

    assign rd_data = mem_q[head_q];
    assign cnt     = cnt_q;

endmodule

// File: rtl/fifo_rd_prefetch.sv
// fifo_rd_prefetch: pops a fixed-latency dual-clock FIFO into a prefetch buffer and streams it out; optional FIFO_RD_STATS_EN adds word/stall counters
module fifo_rd_prefetch
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                    rclk,
    input  logic                    rst_n,
    input  logic                    rempty,
    output logic                    rinc,
    input  logic [WIDTH-1:0]        rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    flush,
    output logic                    flush_done,
    output logic [cnt_w(DEPTH)-1:0] level
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0]             word_cnt,
    output logic [15:0]             stall_cnt
`endif
);

    localparam int OW = cnt_w(DEPTH + RD_LAT);

    state_t            state_q, state_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic              flush_done_q, flush_done_d;
    logic [OW-1:0]     occ;
    logic              clr, wr_en, hs;

    // credit check counts in-flight pops so the buffer can never overflow; rinc held low in reset
    always_comb begin
        occ = OW'(level);
        for (int i = 0; i < RD_LAT; i++) occ = occ + OW'(vld_q[i]);
        rinc  = rst_n & (state_q == RUN) & ~rempty & (occ < OW'(DEPTH));
        vld_d = (vld_q << 1) | RD_LAT'(rinc);
    end

    // RUN takes a flush and clears the buffer; FLUSH waits for the pipe to drain
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        clr          = 1'b0;
        if (state_q == RUN) begin
            if (flush) begin
                state_d = FLUSH;
                clr     = 1'b1;
            end
        end else if (vld_q == '0) begin
            state_d      = RUN;
            flush_done_d = 1'b1;
        end
        out_valid = (level != '0) & (state_q == RUN);
        hs        = out_valid & out_ready;
        wr_en     = vld_q[RD_LAT-1] & (state_q == RUN);
    end

    // FSM, in-flight pipe and completion pulse registers
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            vld_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vld_q        <= vld_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign flush_done = flush_done_q;

    fifo_rd_buf #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_buf (
        .rclk    (rclk),
        .rst_n   (rst_n),
        .clr     (clr),
        .wr_en   (wr_en),
        .wr_data (rdata),
        .rd_en   (hs),
        .rd_data (out_data),
        .cnt     (level)
    );

`ifdef FIFO_RD_STATS_EN
    logic [15:0] word_cnt_q, word_cnt_d, stall_cnt_q, stall_cnt_d;

    // saturating counters, zeroed on the edge that produces flush_done
    always_comb begin
        word_cnt_d  = flush_done_d ? '0 : word_cnt_q + 16'(hs & (word_cnt_q != 16'hFFFF));
        stall_cnt_d = flush_done_d ? '0 :
                      stall_cnt_q + 16'(out_valid & ~out_ready & (stall_cnt_q != 16'hFFFF));
    end

    // statistics registers
    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign word_cnt  = word_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// tb_fifo_rd_prefetch: directed vector table plus multi-cycle sequences against a FIFO read-latency model
module tb_fifo_rd_prefetch;

    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        rclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rempty;
    logic        rinc;
    logic [31:0] rdata;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        flush = 1'b0;
    logic        flush_done;
    logic [2:0]  level;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] word_cnt, stall_cnt;
`endif

    logic        hold_empty = 1'b0;
    logic [31:0] fmem [64];
    int          wr_ptr = 0;
    int          rd_ptr;
    logic [31:0] pipe;
    int          pop_err = 0;

    int          n_cmp = 0, n_bad = 0;
    logic [31:0] exp_base;
    int          exp_idx, n_rinc, first_ov, last_hs;

    typedef struct {
        logic       rdy;
        logic       rinc;
        logic       ov;
        logic [7:0] data;
        logic [2:0] lvl;
    } vec_t;
    vec_t tv [15];

    fifo_rd_prefetch dut (
        .rclk       (rclk),
        .rst_n      (rst_n),
        .rempty     (rempty),
        .rinc       (rinc),
        .rdata      (rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .flush_done (flush_done),
        .level      (level)
`ifdef FIFO_RD_STATS_EN
        ,
        .word_cnt   (word_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 rclk = ~rclk;

    assign rempty = hold_empty | (rd_ptr == wr_ptr);

    // FIFO model: word popped at edge k is on rdata for the capture at edge k+2
    always @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 0;
            pipe   <= JUNK;
            rdata  <= JUNK;
        end else begin
            if (rinc) rd_ptr <= rd_ptr + 1;
            if (rinc && rd_ptr == wr_ptr) pop_err <= pop_err + 1;
            pipe  <= rinc ? fmem[rd_ptr] : JUNK;
            rdata <= pipe;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int n, input logic [31:0] base);
        rst_n      = 1'b0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        hold_empty = 1'b0;
        for (int i = 0; i < n; i++) fmem[i] = base + 32'(i);
        wr_ptr   = n;
        exp_base = base;
        exp_idx  = 0;
        n_rinc   = 0;
        first_ov = -1;
        last_hs  = -1;
        repeat (2) @(posedge rclk);
        #1 rst_n = 1'b1;
    endtask

    task automatic vec(input logic rdy, input logic fl, input logic he);
        @(negedge rclk);
        out_ready  = rdy;
        flush      = fl;
        hold_empty = he;
        #2;
    endtask

    task automatic track(input int c);
        if (out_valid && first_ov < 0) first_ov = c;
        if (rinc) begin
            n_rinc++;
            chk("pop_on_empty", {31'b0, rempty}, 32'd0);
        end
        if (out_valid && out_ready) begin
            chk("stream", out_data, exp_base + 32'(exp_idx));
            exp_idx++;
            last_hs = c;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
        tv[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
        tv[3]  = '{1'b0, 1'b1, 1'b1, 8'hA0, 3'd1};
        tv[4]  = '{1'b0, 1'b0, 1'b1, 8'hA0, 3'd2};
        tv[5]  = '{1'b0, 1'b0, 1'b1, 8'hA0, 3'd3};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 8'hA0, 3'd4};
        tv[7]  = '{1'b1, 1'b0, 1'b1, 8'hA0, 3'd4};
        tv[8]  = '{1'b1, 1'b1, 1'b1, 8'hA1, 3'd3};
        tv[9]  = '{1'b1, 1'b1, 1'b1, 8'hA2, 3'd2};
        tv[10] = '{1'b1, 1'b0, 1'b1, 8'hA3, 3'd1};
        tv[11] = '{1'b0, 1'b0, 1'b1, 8'hA4, 3'd1};
        tv[12] = '{1'b1, 1'b0, 1'b1, 8'hA4, 3'd2};
        tv[13] = '{1'b1, 1'b0, 1'b1, 8'hA5, 3'd1};
        tv[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0};

        // reset values while data is available
        for (int i = 0; i < 4; i++) fmem[i] = 32'h11 + 32'(i);
        wr_ptr = 4;
        repeat (2) @(posedge rclk);
        #2;
        chk("rst_rinc", {31'b0, rinc}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_flush_done", {31'b0, flush_done}, 32'd0);
        chk("rst_level", {29'b0, level}, 32'd0);

        // table: fill to DEPTH under backpressure, drain, empty boundary
        load(6, 32'hA0);
        for (int i = 0; i < 15; i++) begin
            vec(tv[i].rdy, 1'b0, 1'b0);
            chk($sformatf("tv%0d_rinc", i), {31'b0, rinc}, {31'b0, tv[i].rinc});
            chk($sformatf("tv%0d_valid", i), {31'b0, out_valid}, {31'b0, tv[i].ov});
            chk($sformatf("tv%0d_level", i), {29'b0, level}, {29'b0, tv[i].lvl});
            if (tv[i].ov) chk($sformatf("tv%0d_data", i), out_data, {24'b0, tv[i].data});
        end

        // burst throughput: 16 back-to-back pops and deliveries
        load(16, 32'h00);
        for (int c = 0; c < 25; c++) begin
            vec(1'b1, 1'b0, 1'b0);
            track(c);
            if (c == 15) chk("burst_rinc_run", 32'(n_rinc), 32'd16);
        end
        chk("burst_first_valid", 32'(first_ov), 32'd3);
        chk("burst_last_hs", 32'(last_hs), 32'd18);
        chk("burst_count", 32'(exp_idx), 32'd16);

        // rempty toggling every cycle
        load(8, 32'h50);
        for (int c = 0; c < 40; c++) begin
            vec(1'b1, 1'b0, c[0]);
            track(c);
        end
        chk("toggle_count", 32'(exp_idx), 32'd8);
        chk("toggle_pops", 32'(n_rinc), 32'd8);

        // flush with two buffered and two in flight
        load(10, 32'h70);
        for (int c = 0; c < 4; c++) begin
            vec(1'b0, 1'b0, 1'b0);
            track(c);
        end
        vec(1'b0, 1'b1, 1'b0);
        chk("fl_pre_level", {29'b0, level}, 32'd2);
        chk("fl_pre_rinc", {31'b0, rinc}, 32'd0);
        vec(1'b0, 1'b1, 1'b0);
        chk("fl_valid", {31'b0, out_valid}, 32'd0);
        chk("fl_rinc", {31'b0, rinc}, 32'd0);
        chk("fl_level", {29'b0, level}, 32'd0);
        chk("fl_done_early1", {31'b0, flush_done}, 32'd0);
        vec(1'b0, 1'b1, 1'b0);
        chk("fl_done_early2", {31'b0, flush_done}, 32'd0);
        exp_idx = 4;
        vec(1'b1, 1'b0, 1'b0);
        chk("fl_done", {31'b0, flush_done}, 32'd1);
        track(7);
        for (int c = 8; c < 26; c++) begin
            vec(1'b1, 1'b0, 1'b0);
            if (c == 8) chk("fl_done_pulse", {31'b0, flush_done}, 32'd0);
            track(c);
        end
        chk("fl_resume_count", 32'(exp_idx), 32'd10);

        // flush with nothing buffered or in flight
        vec(1'b1, 1'b1, 1'b0);
        chk("fe_rinc", {31'b0, rinc}, 32'd0);
        vec(1'b1, 1'b0, 1'b0);
        chk("fe_valid", {31'b0, out_valid}, 32'd0);
        chk("fe_done_early", {31'b0, flush_done}, 32'd0);
        vec(1'b1, 1'b0, 1'b0);
        chk("fe_done", {31'b0, flush_done}, 32'd1);

        // asynchronous reset in the middle of a burst
        load(16, 32'h30);
        for (int c = 0; c < 6; c++) begin
            vec(1'b1, 1'b0, 1'b0);
            track(c);
        end
        chk("ar_pre_valid", {31'b0, out_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_rinc", {31'b0, rinc}, 32'd0);
        chk("ar_valid", {31'b0, out_valid}, 32'd0);
        chk("ar_data", out_data, 32'd0);
        chk("ar_level", {29'b0, level}, 32'd0);
        chk("ar_done", {31'b0, flush_done}, 32'd0);
        load(5, 32'h90);
        for (int c = 0; c < 15; c++) begin
            vec(1'b1, 1'b0, 1'b0);
            track(c);
        end
        chk("ar_restart_count", 32'(exp_idx), 32'd5);
        chk("fifo_pop_err", 32'(pop_err), 32'd0);

`ifdef FIFO_RD_STATS_EN
        // statistics: 7 stall cycles then 20 handshakes, cleared by flush
        load(20, 32'hC0);
        for (int c = 0; c < 45; c++) begin
            vec(c >= 10, 1'b0, 1'b0);
            track(c);
        end
        chk("st_count", 32'(exp_idx), 32'd20);
        chk("st_word_cnt", {16'b0, word_cnt}, 32'd20);
        chk("st_stall_cnt", {16'b0, stall_cnt}, 32'd7);
        vec(1'b0, 1'b1, 1'b0);
        vec(1'b0, 1'b0, 1'b0);
        vec(1'b0, 1'b0, 1'b0);
        chk("st_flush_done", {31'b0, flush_done}, 32'd1);
        chk("st_word_clr", {16'b0, word_cnt}, 32'd0);
        chk("st_stall_clr", {16'b0, stall_cnt}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
